// File: rtl/ct_ifu_predecd_refill_wr.sv
// Refill-to-predecode writer: predecodes 128-bit refill beats and queues them for the predecode array.
// Optional PREDECD_PARITY_EN widens predecd_din to 33 bits with even parity in bit 32.
module ct_ifu_predecd_refill_wr (
   input  logic          forever_cpuclk,
   input  logic          cpurst,
   input  logic          refill_vld,
   output logic          refill_rdy,
   input  logic          refill_first,
   input  logic [13:0]   refill_index,
   input  logic [127:0]  refill_data,
   input  logic          arb_gnt,
   output logic          predecd_cen_b,
   output logic          predecd_wen_b,
   output logic [15:0]   predecd_index,
`ifdef PREDECD_PARITY_EN
   output logic [32:0]   predecd_din,
`else
   output logic [31:0]   predecd_din,
`endif
   output logic          refill_done,
   output logic          refill_err
);

   typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_e;

   state_e        state_q, state_d;
   logic [13:0]   line_idx_q, line_idx_d;
   logic [1:0]    beat_cnt_q, beat_cnt_d;
   logic          carry_q, carry_d;
   logic          err_q, err_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [15:0]   idx0_q, idx0_d, idx1_q, idx1_d;
   logic [31:0]   din0_q, din0_d, din1_q, din1_d;

   logic [7:0][15:0] hw;
   logic [7:0]       pd_start, pd_is32, pd_br, pd_jr;
   logic [7:0][3:0]  pd_nib;
   logic [31:0]      pd_din;
   logic             carry_new;
   logic             accept, push, pop;
   logic [1:0]       occ;
   logic [15:0]      push_idx;
   logic [31:0]      head_din;

   assign hw = refill_data;

   // Instruction-boundary chain: a 32-bit start consumes the following halfword.
   always_comb begin
      logic [2:0] k, kp;
      pd_start = '0;
      pd_is32  = '0;
      pd_br    = '0;
      pd_jr    = '0;
      pd_nib   = '0;
      k        = '0;
      kp       = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         k  = 3'(i);
         kp = k - 3'd1;
         if (i == 0)
            pd_start[k] = refill_first | ~carry_q;
         else
            pd_start[k] = ~(pd_start[kp] & pd_is32[kp]);
         pd_is32[k] = pd_start[k] & (hw[k][1:0] == 2'b11);
         if (pd_is32[k]) begin
            pd_br[k] = (hw[k][6:0] == 7'b1100011) | (hw[k][6:0] == 7'b1101111);
            pd_jr[k] = (hw[k][6:0] == 7'b1100111);
         end else begin
            pd_br[k] = pd_start[k] & (hw[k][1:0] == 2'b01) & (hw[k][15:13] >= 3'b101);
            pd_jr[k] = pd_start[k] & (hw[k][1:0] == 2'b10) & (hw[k][15:13] == 3'b100)
                       & (hw[k][6:2] == 5'd0) & (hw[k][11:7] != 5'd0);
         end
         pd_nib[k] = {pd_jr[k], pd_br[k], pd_is32[k], pd_start[k]};
      end
   end

   assign pd_din    = pd_nib;
   assign carry_new = pd_start[7] & pd_is32[7];

   assign accept   = refill_vld & refill_rdy;
   assign push     = accept & (refill_first | (state_q == FILL));
   assign pop      = (cnt_q != 2'd0) & arb_gnt;
   assign occ      = cnt_q - {1'b0, pop};
   assign push_idx = refill_first ? {refill_index, 2'b00} : {line_idx_q, beat_cnt_q + 2'd1};

   always_comb begin
      line_idx_d = line_idx_q;
      beat_cnt_d = beat_cnt_q;
      carry_d    = carry_q;
      err_d      = err_q;
      idx0_d     = idx0_q;
      din0_d     = din0_q;
      idx1_d     = idx1_q;
      din1_d     = din1_q;
      if (accept) begin
         if (refill_first) begin
            line_idx_d = refill_index;
            beat_cnt_d = 2'd0;
            carry_d    = carry_new;
            if (state_q == FILL) err_d = 1'b1;
         end else if (state_q == FILL) begin
            beat_cnt_d = beat_cnt_q + 2'd1;
            carry_d    = carry_new;
         end else begin
            err_d = 1'b1;
         end
      end
      // Pop shifts slot 1 forward; the push then lands in the first free slot.
      if (pop) begin
         idx0_d = idx1_q;
         din0_d = din1_q;
      end
      if (push) begin
         if (occ == 2'd0) begin
            idx0_d = push_idx;
            din0_d = pd_din;
         end else begin
            idx1_d = push_idx;
            din1_d = pd_din;
         end
      end
      cnt_d = occ + {1'b0, push};
   end

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         state_q    <= IDLE;
         line_idx_q <= '0;
         beat_cnt_q <= '0;
         carry_q    <= 1'b0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
         idx0_q     <= '0;
         din0_q     <= '0;
         idx1_q     <= '0;
         din1_q     <= '0;
      end else begin
         state_q    <= state_d;
         line_idx_q <= line_idx_d;
         beat_cnt_q <= beat_cnt_d;
         carry_q    <= carry_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
         idx0_q     <= idx0_d;
         din0_q     <= din0_d;
         idx1_q     <= idx1_d;
         din1_q     <= din1_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept & refill_first) state_d = FILL;
         FILL:    if (accept & ~refill_first & (beat_cnt_q == 2'd2)) state_d = DRAIN;
         DRAIN:   if (cnt_d == 2'd0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are masked by cpurst so nothing is written during the reset cycle.
   always_comb begin
      refill_rdy    = ~cpurst & (state_q != DRAIN) & (cnt_q != 2'd2);
      refill_done   = ~cpurst & (state_q == DRAIN) & (cnt_d == 2'd0);
      refill_err    = ~cpurst & err_q;
      predecd_cen_b = 1'b1;
      predecd_wen_b = 1'b1;
      predecd_index = '0;
      head_din      = '0;
      if (~cpurst & (cnt_q != 2'd0)) begin
         predecd_cen_b = 1'b0;
         predecd_wen_b = 1'b0;
         predecd_index = idx0_q;
         head_din      = din0_q;
      end
   end

`ifdef PREDECD_PARITY_EN
   assign predecd_din = {^head_din, head_din};
`else
   assign predecd_din = head_din;
`endif

endmodule

// File: doc/ct_ifu_predecd_refill_wr.md
CT_IFU_PREDECD_REFILL_WR -- requirements
Module: ct_ifu_predecd_refill_wr

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset (forever_cpuclk, cpurst).
REQ-002 SHALL expose these ports:
- forever_cpuclk  in  1  clock, rising edge.
- cpurst  in  1  synchronous, active-high reset.
- refill_vld  in  1  refill beat valid.
- refill_rdy  out  1  beat accepted when vld&rdy.
- refill_first  in  1  beat is beat 0 of a 64B line.
- refill_index  in  14  line index, sampled on first beat.
- refill_data  in  128  8 halfwords; h[i]=data[16i+15:16i].
- arb_gnt  in  1  predecode array port granted this cycle.
- predecd_cen_b  out  1  array chip enable, active-low.
- predecd_wen_b  out  1  array write enable, active-low.
- predecd_index  out  16  {line_idx, beat_cnt}.
- predecd_din  out  32 (33 with REQ-020)  predecode word.
- refill_done  out  1  one-cycle pulse, line fully written.
- refill_err  out  1  sticky protocol error.

Function
REQ-003 SHALL combinationally predecode each accepted beat into 4 bits per halfword, din[4i+3:4i] = {jr, br, is32, start}.
REQ-004 start[0] SHALL be 1 on a first beat; otherwise start[0] = !carry, where carry = start[7]&is32[7] of the previous beat.
- For i>0: start[i] = !(start[i-1]&is32[i-1]).
REQ-005 is32[i] SHALL equal start[i] & (h[i][1:0]==2'b11).
REQ-006 br[i] SHALL equal start[i] & (is32 ? h[6:0] in {1100011, 1101111} : h[1:0]==01 & h[15:13] in {101, 110, 111}).
REQ-007 jr[i] SHALL equal start[i] & (is32 ? h[6:0]==1100111 : h[1:0]==10 & h[15:13]==100 & h[6:2]==0 & h[11:7]!=0).
REQ-008 Accepted beats SHALL be pushed, predecoded, with their index, into a 2-entry FIFO.
- refill_rdy = (state!=DRAIN) & !full.
- No bypass: a full FIFO deasserts rdy even if a pop occurs in the same cycle.
REQ-009 When the FIFO is non-empty, the block SHALL drive predecd_cen_b=0, predecd_wen_b=0 and the head index/din.
- The head SHALL pop only in a cycle with arb_gnt=1; otherwise the head holds.
- When the FIFO is empty: cen_b=1, wen_b=1, index=0, din=0.
REQ-010 A beat accepted in cycle N SHALL appear on the predecd ports in cycle N+1 at the earliest.
REQ-011 FSM SHALL have states IDLE, FILL and DRAIN.
- IDLE to FILL on an accepted first beat: latch refill_index, beat_cnt=0.
- FILL: each accepted beat increments beat_cnt; the 4th beat (beat_cnt==3) moves to DRAIN.
- DRAIN to IDLE when the FIFO becomes empty; refill_done=1 for exactly that cycle.
REQ-012 A non-first beat accepted in IDLE SHALL be discarded (no push) and SHALL set refill_err.
REQ-013 A first beat accepted in FILL SHALL set refill_err, restart the line (new index, beat_cnt=0, carry cleared) and be pushed.
REQ-014 beat_cnt SHALL be 2 bits and SHALL never wrap within a line; the state leaves FILL at 3.
REQ-015 Push and pop in the same cycle SHALL keep the occupancy unchanged.

Reset
REQ-016 While cpurst=1, the block SHALL hold state=IDLE, FIFO empty, carry=0, beat_cnt=0 and refill_err=0.
REQ-017 While cpurst=1, outputs SHALL be: refill_rdy=0, cen_b=1, wen_b=1, index=0, din=0, refill_done=0.
REQ-018 In the first cycle after cpurst deasserts, refill_rdy SHALL be 1.
REQ-019 Reset asserted mid-line SHALL drop all pending entries; no array write SHALL occur in the reset cycle or after it.

Configuration
REQ-020 With PREDECD_PARITY_EN defined, predecd_din SHALL be 33 bits, with bit32 = XOR of bits 31:0 (even parity).
- Without the macro, predecd_din SHALL be 32 bits and no parity logic SHALL exist.

Verification
REQ-021 Reset, then a 4-beat line (index 14'h0005, arb_gnt=1, all halfwords 16'h0001) -> writes at indexes 0x14, 0x15, 0x16, 0x17, each with din 32'h11111111; refill_done pulses once.
REQ-022 Beat 0 h[7]=16'h0013 (32-bit start) -> next beat bit0 start[0]=0, din[3:0]=0; start[1]=1.
REQ-023 arb_gnt=0 for 5 cycles during a line -> FIFO fills, refill_rdy=0 after 2 beats; head index/din stable; no beat lost after gnt returns.
REQ-024 Non-first beat in IDLE -> no write, refill_err=1 sticky; a first beat at beat_cnt=2 -> refill_err=1, restart at {new_idx, 2'b00}.
REQ-025 cpurst=1 while FIFO holds 2 entries -> cen_b=1 next cycle, no further writes, refill_rdy=1 after release.
REQ-026 PREDECD_PARITY_EN defined, din bits 31:0 = 32'h00000007 -> din[32]=1.
